// File: rtl/idli_uart_rx_m_if.sv
// idli_uart_rx_if: byte delivery handshake and error pulses of idli_uart_rx_m.
// o_urx_perr exists only when IDLI_UART_RX_PARITY_EN is defined.
interface idli_uart_rx_if;
    logic [7:0] o_urx_data;
    logic       o_urx_vld;
    logic       i_urx_rdy;
    logic       o_urx_ferr;
    logic       o_urx_ovf;
`ifdef IDLI_UART_RX_PARITY_EN
    logic       o_urx_perr;
`endif

    modport master (
        input  i_urx_rdy,
        output o_urx_data, o_urx_vld, o_urx_ferr, o_urx_ovf
`ifdef IDLI_UART_RX_PARITY_EN
        , output o_urx_perr
`endif
    );

    modport slave (
        output i_urx_rdy,
        input  o_urx_data, o_urx_vld, o_urx_ferr, o_urx_ovf
`ifdef IDLI_UART_RX_PARITY_EN
        , input o_urx_perr
`endif
    );
endinterface

// File: rtl/idli_uart_rx_m.sv
// idli_uart_rx_m: oversampling UART receiver (8N1) feeding a small byte FIFO.
// Define IDLI_UART_RX_PARITY_EN for 8E1 frames and the o_urx_perr pulse.
module idli_uart_rx_m #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           i_urx_gck,
    input  logic           i_urx_rst_n,
    input  logic           i_urx_rx,
    idli_uart_rx_if.master urx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] DEPTH    = PW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef IDLI_UART_RX_PARITY_EN
        S_PAR,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic          sync_q1;
    logic          sync_q2;
    logic          rx_s;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          bit_tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic [7:0]    rx_byte;
    logic          push_q;
    logic          ferr_q;
`ifdef IDLI_UART_RX_PARITY_EN
    logic          par_q;
    logic          perr_q;
    logic          perr_out;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] count;
    logic          fifo_full;
    logic          pop;
    logic          wr_en;
    logic          ferr_out;
    logic          ovf_out;
    logic          unused_ptr_msb;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= i_urx_rx;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_s     = sync_q2;
    assign bit_tick = (cnt == '0);

    // Frame FSM; push/error events are registered here and land one edge later.
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            rx_byte <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef IDLI_UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef IDLI_UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= CNT_HALF;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (!bit_tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= S_IDLE;
                    end else begin
                        cnt     <= CNT_FULL;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!bit_tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt     <= CNT_FULL;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef IDLI_UART_RX_PARITY_EN
                            state <= S_PAR;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef IDLI_UART_RX_PARITY_EN
                S_PAR: begin
                    if (!bit_tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= CNT_FULL;
                        par_q <= rx_s;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (!bit_tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        cnt     <= '0;
                        rx_byte <= shift_q;
                        state   <= S_IDLE;
`ifdef IDLI_UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_q <= 1'b1;
                        end else begin
                            push_q <= 1'b1;
                        end
`else
                        push_q <= 1'b1;
`endif
                    end else begin
                        cnt    <= '0;
                        ferr_q <= 1'b1;
                        state  <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fifo_full = (count == DEPTH);
    assign pop       = (count != '0) && urx.i_urx_rdy;
    assign wr_en     = push_q && (!fifo_full || pop);

    // A pop frees the head slot on the same edge, so a full FIFO still takes the push.
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ferr_out <= 1'b0;
            ovf_out  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ferr_out <= ferr_q;
            ovf_out  <= push_q && fifo_full && !pop;
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= rx_byte;
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef IDLI_UART_RX_PARITY_EN
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            perr_out <= 1'b0;
        end else begin
            perr_out <= perr_q;
        end
    end

    assign urx.o_urx_perr = perr_out;
`endif

    assign unused_ptr_msb = rd_ptr[PW-1] ^ wr_ptr[PW-1];

    assign urx.o_urx_vld  = (count != '0);
    assign urx.o_urx_data = mem[rd_ptr[AW-1:0]];
    assign urx.o_urx_ferr = ferr_out;
    assign urx.o_urx_ovf  = ovf_out;
endmodule

// File: tb/tb_idli_uart_rx_m.sv
// tb_idli_uart_rx_m: directed, table-driven and random frames against a
// cycle-level queue model of the receiver's delivery rules.
`timescale 1ns/1ps
module tb_idli_uart_rx_m;
    localparam int N = 16;
    localparam int D = 4;
`ifdef IDLI_UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = 3 + N / 2 + (9 + P) * N;

    typedef struct {
        int         cyc_at;
        logic [7:0] data;
        logic       push;
        logic       ferr;
        logic       perr;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       pflip;
        int         low;
        int         exp_acc;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_last;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic rdy   = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ev_t        pend[$];
    logic [7:0] mq[$];
    logic [7:0] dut_log[$];
    logic       e_ferr, e_ovf, e_perr;
    logic       full_b, pop_b, exp_vld;
    logic [7:0] exp_data;
    logic       p_vld;
    logic [7:0] p_data;
    logic       perr_act;
    int         d_ferr = 0, d_ovf = 0, d_perr = 0;
    ev_t        ev;

    idli_uart_rx_if urx ();
    assign urx.i_urx_rdy = rdy;

    idli_uart_rx_m #(
        .CLKS_PER_BIT(N),
        .FIFO_DEPTH  (D)
    ) dut (
        .i_urx_gck  (clk),
        .i_urx_rst_n(rst_n),
        .i_urx_rx   (rx),
        .urx        (urx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One frame, LSB first; the model learns when its result must appear.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pflip, input int low_after);
        ev_t e;
        @(negedge clk);
        rx = 1'b0;
        e.cyc_at = cyc + 1 + LAT;
        e.data   = d;
        e.ferr   = !stop;
        e.perr   = stop && pflip && (P == 1);
        e.push   = stop && !e.perr;
        pend.push_back(e);
        repeat (N) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            repeat (N) @(negedge clk);
        end
        if (P == 1) begin
            rx = (^d) ^ pflip;
            repeat (N) @(negedge clk);
        end
        rx = stop;
        repeat (N) @(negedge clk);
        if (!stop) begin
            rx = 1'b0;
            repeat (low_after) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Reference model: FIFO as a queue, events applied at their due cycle.
    always @(posedge clk) begin
        cyc++;
        e_ferr = 1'b0;
        e_ovf  = 1'b0;
        e_perr = 1'b0;
        if (!rst_n) begin
            mq.delete();
            pend.delete();
        end else begin
            if (p_vld && rdy) dut_log.push_back(p_data);
            full_b = (mq.size() == D);
            pop_b  = (mq.size() != 0) && rdy;
            if (pop_b) void'(mq.pop_front());
            while (pend.size() != 0 && pend[0].cyc_at <= cyc) begin
                ev = pend.pop_front();
                if (ev.cyc_at == cyc) begin
                    if (ev.ferr) e_ferr = 1'b1;
                    else if (ev.perr) e_perr = 1'b1;
                    else if (ev.push) begin
                        if (full_b && !pop_b) e_ovf = 1'b1;
                        else mq.push_back(ev.data);
                    end
                end
            end
        end
        #1;
        exp_vld  = rst_n && (mq.size() != 0);
        exp_data = 8'h00;
        if (exp_vld) exp_data = mq[0];
`ifdef IDLI_UART_RX_PARITY_EN
        perr_act = urx.o_urx_perr;
`else
        perr_act = 1'b0;
`endif
        check("cycle_vld_ferr_ovf_perr_data",
              {urx.o_urx_vld, urx.o_urx_ferr, urx.o_urx_ovf, perr_act,
               (exp_vld || !rst_n) ? urx.o_urx_data : 8'h00},
              {exp_vld, e_ferr, e_ovf, e_perr, exp_data});
        p_vld  = urx.o_urx_vld;
        p_data = urx.o_urx_data;
        if (urx.o_urx_ferr) d_ferr++;
        if (urx.o_urx_ovf)  d_ovf++;
        if (perr_act)       d_perr++;
    end

    vec_t vt[$];
    int   b_log, b_f, b_o, b_p;
    logic [7:0] r;
    logic rdone;
    logic [7:0] drain_exp [4];

    initial begin
        vt.push_back('{8'h5A, 1'b1, 1'b0, 0,     1, 0, 0, 8'h5A});
        vt.push_back('{8'h00, 1'b1, 1'b0, 0,     1, 0, 0, 8'h00});
        vt.push_back('{8'hFF, 1'b1, 1'b0, 0,     1, 0, 0, 8'hFF});
        vt.push_back('{8'h3C, 1'b0, 1'b0, 3 * N, 0, 1, 0, 8'h00});
        vt.push_back('{8'h81, 1'b1, 1'b0, 0,     1, 0, 0, 8'h81});
        vt.push_back('{8'hC3, 1'b0, 1'b0, 0,     0, 1, 0, 8'h00});
        vt.push_back('{8'h7E, 1'b1, 1'b0, 0,     1, 0, 0, 8'h7E});
`ifdef IDLI_UART_RX_PARITY_EN
        vt.push_back('{8'h07, 1'b1, 1'b0, 0,     1, 0, 0, 8'h07});
        vt.push_back('{8'h07, 1'b1, 1'b1, 0,     0, 0, 1, 8'h00});
        vt.push_back('{8'h96, 1'b1, 1'b1, 0,     0, 0, 1, 8'h00});
`endif
        drain_exp[0] = 8'h02;
        drain_exp[1] = 8'h03;
        drain_exp[2] = 8'h04;
        drain_exp[3] = 8'h06;

        repeat (3) @(negedge clk);
        check("reset_vld", urx.o_urx_vld, 0);
        check("reset_data", urx.o_urx_data, 8'h00);
        check("reset_errs", {urx.o_urx_ferr, urx.o_urx_ovf}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic byte with exact latency.
        rdy = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 0);
            begin
                @(negedge clk);
                repeat (LAT) @(posedge clk);
                #1 check("basic_before", urx.o_urx_vld, 0);
                @(posedge clk);
                #1 check("basic_vld_data", {urx.o_urx_vld, urx.o_urx_data}, {1'b1, 8'hA5});
                @(posedge clk);
                #1 check("basic_popped", urx.o_urx_vld, 0);
            end
        join
        repeat (N) @(negedge clk);

        // Glitch shorter than half a bit.
        b_log = dut_log.size(); b_f = d_ferr; b_o = d_ovf;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * N) @(negedge clk);
        check("glitch_nobyte", dut_log.size(), b_log);
        check("glitch_noerr", d_ferr + d_ovf, b_f + b_o);

        // Framing error pulse timing, then a clean byte.
        b_log = dut_log.size(); b_f = d_ferr;
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 3 * N);
            begin
                @(negedge clk);
                repeat (LAT) @(posedge clk);
                #1 check("ferr_before", urx.o_urx_ferr, 0);
                @(posedge clk);
                #1 check("ferr_pulse", urx.o_urx_ferr, 1);
                @(posedge clk);
                #1 check("ferr_end", urx.o_urx_ferr, 0);
            end
        join
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        repeat (2 * N) @(negedge clk);
        check("ferr_count", d_ferr - b_f, 1);
        check("ferr_only_5a", dut_log.size() - b_log, 1);
        check("ferr_5a_data", dut_log[$], 8'h5A);

        // Table of frames with rdy held high.
        for (int i = 0; i < vt.size(); i++) begin
            b_log = dut_log.size(); b_f = d_ferr; b_p = d_perr;
            send_frame(vt[i].d, vt[i].stop, vt[i].pflip, vt[i].low);
            repeat (2 * N) @(negedge clk);
            check($sformatf("vec%0d_acc", i), dut_log.size() - b_log, vt[i].exp_acc);
            check($sformatf("vec%0d_ferr", i), d_ferr - b_f, vt[i].exp_ferr);
            check($sformatf("vec%0d_perr", i), d_perr - b_p, vt[i].exp_perr);
            if (vt[i].exp_acc != 0 && dut_log.size() != 0)
                check($sformatf("vec%0d_data", i), dut_log[$], vt[i].exp_last);
        end

        // Overflow, then push and pop on the same edge while full.
        rdy = 1'b0;
        b_log = dut_log.size(); b_o = d_ovf;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, 0);
        repeat (2 * N) @(negedge clk);
        check("ovf_once", d_ovf - b_o, 1);
        check("ovf_head", {urx.o_urx_vld, urx.o_urx_data}, {1'b1, 8'h01});
        fork
            send_frame(8'h06, 1'b1, 1'b0, 0);
            begin
                @(negedge clk);
                repeat (LAT) @(posedge clk);
                @(negedge clk);
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
            end
        join
        repeat (2 * N) @(negedge clk);
        check("same_cycle_no_ovf", d_ovf - b_o, 1);
        check("same_cycle_popped", dut_log.size() - b_log, 1);
        if (dut_log.size() > b_log) check("same_cycle_first", dut_log[b_log], 8'h01);
        rdy = 1'b1;
        repeat (10) @(negedge clk);
        check("drain_count", dut_log.size() - b_log, 5);
        for (int i = 0; i < 4; i++)
            if (dut_log.size() > b_log + 1 + i)
                check($sformatf("drain%0d", i), dut_log[b_log + 1 + i], drain_exp[i]);

        // Reset in the middle of a frame.
        b_log = dut_log.size();
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 0);
            begin
                @(negedge clk);
                repeat (2 + N / 2 + 4 * N + 2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b0;
                @(posedge clk);
                #1 check("rst_mid_outputs",
                         {urx.o_urx_vld, urx.o_urx_ferr, urx.o_urx_ovf, urx.o_urx_data}, 0);
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        repeat (2 * N) @(negedge clk);
        check("rst_only_81", dut_log.size() - b_log, 1);
        check("rst_81_data", dut_log[$], 8'h81);

        // Random frames with bursty consumer back-pressure.
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    r = 8'($urandom);
                    repeat ($urandom_range(0, 2 * N)) @(negedge clk);
                    send_frame(r, $urandom_range(0, 7) != 0,
                               (P == 1) && ($urandom_range(0, 5) == 0),
                               $urandom_range(0, 2 * N));
                end
                repeat (4 * N) @(negedge clk);
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    rdy = ($urandom_range(0, 2) == 0);
                    if (rdy) repeat ($urandom_range(1, 60)) @(negedge clk);
                    else repeat ($urandom_range(1, 900)) @(negedge clk);
                end
            end
        join
        rdy = 1'b1;
        repeat (20) @(negedge clk);
        check("final_empty", urx.o_urx_vld, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
